fb_count_monitor: RTL
=====================

FB_COUNT_MONITOR -- requirements
Module: fb_count_monitor

Interface
REQ-001 SHALL have parameter _RAM_WIDTH, default 32, setting the width of the count, snapshot and timeout-window fields.
REQ-002 SHALL have port io_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port io_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port io_fb_catch, input, 1 bit: single-cycle pulse from the upstream catch stage, one per validated feedback pulse.
REQ-005 SHALL have port io_clr, input, 1 bit: synchronous clear of the count and sticky flags.
REQ-006 SHALL have port io_snap, input, 1 bit: request to latch the current count.
REQ-007 SHALL have port io_arm, input, 1 bit: start or restart the feedback timeout window.
REQ-008 SHALL have port io_timeout_cnt, input, _RAM_WIDTH bits: window length in clk cycles.
REQ-009 SHALL have port io_cnt, output, _RAM_WIDTH bits: accumulated feedback count.
REQ-010 SHALL have port io_snap_cnt, output, _RAM_WIDTH bits: latched count.
REQ-011 SHALL have port io_snap_vld, output, 1 bit: single-cycle pulse when io_snap_cnt updates.
REQ-012 SHALL have port io_ovf, output, 1 bit: sticky flag, count saturated.
REQ-013 SHALL have port io_busy, output, 1 bit: timeout window active.
REQ-014 SHALL have port io_hit, output, 1 bit: single-cycle pulse, feedback arrived inside the window.
REQ-015 SHALL have port io_timeout, output, 1 bit: sticky flag, window expired without feedback.

Function
REQ-016 SHALL increment io_cnt by 1 on the clk edge following each io_fb_catch cycle, so io_cnt is visible one cycle after the pulse.
REQ-017 SHALL saturate io_cnt at 2^_RAM_WIDTH-1; a catch pulse at saturation holds the value and sets io_ovf.
REQ-018 SHALL give io_clr priority over counting: io_clr clears io_ovf, io_timeout and io_cnt, except that io_clr and io_fb_catch in the same cycle yield io_cnt=1 (the pulse is not lost).
REQ-019 SHALL, on io_snap, load io_snap_cnt with the post-update count of that same cycle (including a coincident catch or clear) and pulse io_snap_vld exactly one cycle later.
REQ-020 SHALL implement a timeout FSM with states IDLE, WAIT, HIT and TMO.
REQ-021 SHALL, in IDLE, on io_arm go to WAIT, load the timer with io_timeout_cnt and clear io_timeout.
REQ-022 SHALL, in IDLE with io_timeout_cnt=0, on io_arm go directly to TMO.
REQ-023 SHALL, in WAIT, decrement the timer every cycle and hold io_busy=1.
REQ-024 SHALL, in WAIT, go to HIT on io_fb_catch.
REQ-025 SHALL, in WAIT, go to TMO when the timer is 1 and no catch occurs, so the window is exactly io_timeout_cnt cycles.
REQ-026 SHALL, in WAIT, on io_arm reload the timer and stay in WAIT (restart).
REQ-027 SHALL give a catch priority when catch and expiry coincide in WAIT (go to HIT).
REQ-028 SHALL, in HIT, assert io_hit for one cycle and return to IDLE.
REQ-029 SHALL, in TMO, set io_timeout for one cycle's entry and return to IDLE.
REQ-030 SHALL keep io_timeout sticky until io_clr or the next io_arm.
REQ-031 SHALL abort an active window on io_clr: return to IDLE with io_busy=0 and no io_hit or io_timeout.
REQ-032 SHALL count every catch pulse regardless of FSM state.

Reset
REQ-033 SHALL, while io_rst_n=0, asynchronously force io_cnt=0, io_snap_cnt=0, io_snap_vld=0, io_ovf=0, io_busy=0, io_hit=0, io_timeout=0, timer=0 and FSM=IDLE.
REQ-034 SHALL, when reset is asserted mid-window, neither emit nor retain any io_hit or io_timeout.

Configuration
REQ-035 SHALL compile the timer and FSM only when FB_TIMEOUT_EN is defined.
REQ-036 SHALL, without FB_TIMEOUT_EN, tie io_busy, io_hit and io_timeout to 0 and ignore io_arm and io_timeout_cnt; counting and snapshot behaviour are unchanged.

Structure
REQ-037 SHALL take the FSM state encoding (IDLE, WAIT, HIT, TMO as a 2-bit typedef) from the shared feedback package.
REQ-038 SHALL have one natural sub-module, fb_timeout_timer, holding the timer and FSM; it is instantiated only under FB_TIMEOUT_EN.

Verification
REQ-039 SHALL cover: 5 catch pulses spaced 4 clk apart -> io_cnt=5, io_ovf=0.
REQ-040 SHALL cover: _RAM_WIDTH=4, 17 catch pulses -> io_cnt=15, io_ovf=1; then io_clr -> io_cnt=0, io_ovf=0.
REQ-041 SHALL cover: io_clr coincident with a catch at count 9 -> io_cnt=1; io_snap in the same cycle -> io_snap_cnt=1 with io_snap_vld one cycle later.
REQ-042 SHALL cover: io_timeout_cnt=10, io_arm, no catch -> io_busy high 10 cycles, then io_timeout=1 (sticky).
REQ-043 SHALL cover: io_timeout_cnt=10, io_arm, catch on the 10th cycle of the window -> io_hit pulse, io_timeout stays 0.
REQ-044 SHALL cover: io_rst_n low mid-window -> all outputs 0 immediately; io_arm with io_timeout_cnt=0 -> io_timeout=1 two cycles later.

Source files
------------

// File: rtl/fb_count_monitor_pkg.sv
// rtl/fb_count_monitor_pkg.sv - shared feedback package: timeout FSM encoding and defaults
//
// Purpose : Types and constants shared by the feedback count monitor and its
//           timeout window timer.
// Contents: fbTmoState     - 2-bit timeout FSM encoding (IDLE, WAIT, HIT, TMO)
//           FbDefaultWidth - default width of count, snapshot and window fields
//           fbStateBusy()  - true while a timeout window is open

package fb_count_monitor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_HIT  = 2'b10,
    S_TMO  = 2'b11
  } fbTmoState;

  localparam int FbDefaultWidth = 32;

  // The window is open only while waiting; HIT and TMO are single-cycle exits.
  function automatic logic fbStateBusy(input fbTmoState s);
    return (s == S_WAIT);
  endfunction

endpackage

// File: rtl/fb_count_monitor_timer.sv
// rtl/fb_count_monitor_timer.sv - feedback timeout window timer and FSM
//
// Purpose : Opens a window of io_timeout_cnt cycles on io_arm and reports
//           whether a feedback pulse arrived inside it (io_hit) or the window
//           expired first (sticky io_timeout).
// Ports   : io_clk         - clock, rising edge
//           io_rst_n       - asynchronous active-low reset
//           io_catch       - validated feedback pulse
//           io_clr         - synchronous abort of the window, clears io_timeout
//           io_arm         - start or restart the window
//           io_timeout_cnt - window length in cycles (0 expires immediately)
//           io_busy        - window open
//           io_hit         - one-cycle pulse, feedback seen inside the window
//           io_timeout     - sticky, window expired without feedback
// Build   : compiled only when FB_TIMEOUT_EN is defined.

`ifdef FB_TIMEOUT_EN
module fb_timeout_timer
  import fb_count_monitor_pkg::*;
#(
  parameter int _RAM_WIDTH = FbDefaultWidth
) (
  input  logic                  io_clk,
  input  logic                  io_rst_n,
  input  logic                  io_catch,
  input  logic                  io_clr,
  input  logic                  io_arm,
  input  logic [_RAM_WIDTH-1:0] io_timeout_cnt,
  output logic                  io_busy,
  output logic                  io_hit,
  output logic                  io_timeout
);

  localparam logic [_RAM_WIDTH-1:0] TickOne = {{(_RAM_WIDTH-1){1'b0}}, 1'b1};

  fbTmoState             stateQ, stateNext;
  fbTmoState             armTarget;
  logic [_RAM_WIDTH-1:0] timerQ, timerNext;
  logic                  timeoutQ, timeoutNext;

  // A zero-length window has nothing to wait for and expires straight away.
  assign armTarget = (io_timeout_cnt == '0) ? S_TMO : S_WAIT;

  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      stateQ   <= S_IDLE;
      timerQ   <= '0;
      timeoutQ <= 1'b0;
    end else begin
      stateQ   <= stateNext;
      timerQ   <= timerNext;
      timeoutQ <= timeoutNext;
    end
  end

  always_comb begin
    stateNext   = stateQ;
    timerNext   = timerQ;
    timeoutNext = timeoutQ;
    if (io_clr) begin
      // Abort silently: no hit, no timeout, flag cleared.
      stateNext   = S_IDLE;
      timerNext   = '0;
      timeoutNext = 1'b0;
    end else begin
      case (stateQ)
        S_IDLE: begin
          if (io_arm) begin
            stateNext   = armTarget;
            timerNext   = io_timeout_cnt;
            timeoutNext = 1'b0;
          end
        end
        S_WAIT: begin
          // Feedback wins over both a restart and an expiry in the same cycle.
          if (io_catch) begin
            stateNext = S_HIT;
            timerNext = '0;
          end else if (io_arm) begin
            stateNext   = armTarget;
            timerNext   = io_timeout_cnt;
            timeoutNext = 1'b0;
          end else if (timerQ == TickOne) begin
            // Last cycle of the window: it lasted exactly io_timeout_cnt cycles.
            stateNext = S_TMO;
            timerNext = '0;
          end else begin
            timerNext = timerQ - TickOne;
          end
        end
        S_HIT: begin
          stateNext = S_IDLE;
        end
        S_TMO: begin
          stateNext   = S_IDLE;
          timeoutNext = 1'b1;
        end
        default: begin
          stateNext = S_IDLE;
        end
      endcase
    end
  end

  assign io_busy    = fbStateBusy(stateQ);
  assign io_hit     = (stateQ == S_HIT);
  assign io_timeout = timeoutQ;

endmodule
`endif

// File: rtl/fb_count_monitor.sv
// rtl/fb_count_monitor.sv - feedback pulse counter with snapshot and optional timeout window
//
// Purpose : Counts validated feedback pulses (saturating, sticky overflow),
//           latches the count on request and, optionally, checks that
//           feedback arrives within an armed timeout window.
// Ports   : io_clk         - clock, rising edge
//           io_rst_n       - asynchronous active-low reset
//           io_fb_catch    - one-cycle pulse per validated feedback pulse
//           io_clr         - synchronous clear of count and sticky flags
//           io_snap        - latch the post-update count of this cycle
//           io_arm         - start or restart the timeout window
//           io_timeout_cnt - window length in cycles
//           io_cnt         - accumulated feedback count
//           io_snap_cnt    - latched count
//           io_snap_vld    - one-cycle pulse when io_snap_cnt updates
//           io_ovf         - sticky, count saturated
//           io_busy        - timeout window open
//           io_hit         - one-cycle pulse, feedback inside the window
//           io_timeout     - sticky, window expired without feedback
// Build   : FB_TIMEOUT_EN adds fb_timeout_timer; without it io_busy, io_hit
//           and io_timeout read 0 and io_arm / io_timeout_cnt are ignored.

module fb_count_monitor
  import fb_count_monitor_pkg::*;
#(
  parameter int _RAM_WIDTH = FbDefaultWidth
) (
  input  logic                  io_clk,
  input  logic                  io_rst_n,
  input  logic                  io_fb_catch,
  input  logic                  io_clr,
  input  logic                  io_snap,
  input  logic                  io_arm,
  input  logic [_RAM_WIDTH-1:0] io_timeout_cnt,
  output logic [_RAM_WIDTH-1:0] io_cnt,
  output logic [_RAM_WIDTH-1:0] io_snap_cnt,
  output logic                  io_snap_vld,
  output logic                  io_ovf,
  output logic                  io_busy,
  output logic                  io_hit,
  output logic                  io_timeout
);

  localparam logic [_RAM_WIDTH-1:0] CntMax = {_RAM_WIDTH{1'b1}};
  localparam logic [_RAM_WIDTH-1:0] CntOne = {{(_RAM_WIDTH-1){1'b0}}, 1'b1};

  logic [_RAM_WIDTH-1:0] cntQ, cntNext, snapCntQ;
  logic                  ovfQ, ovfNext, snapVldQ;

  always_comb begin
    cntNext = cntQ;
    ovfNext = ovfQ;
    if (io_clr) begin
      // A pulse arriving with the clear starts the new epoch rather than being lost.
      cntNext = io_fb_catch ? CntOne : '0;
      ovfNext = 1'b0;
    end else if (io_fb_catch) begin
      if (cntQ == CntMax) begin
        ovfNext = 1'b1;
      end else begin
        cntNext = cntQ + CntOne;
      end
    end
  end

  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      cntQ     <= '0;
      ovfQ     <= 1'b0;
      snapCntQ <= '0;
      snapVldQ <= 1'b0;
    end else begin
      cntQ     <= cntNext;
      ovfQ     <= ovfNext;
      snapVldQ <= io_snap;
      // Snapshot takes the value io_cnt will show after this edge.
      if (io_snap) begin
        snapCntQ <= cntNext;
      end
    end
  end

  assign io_cnt      = cntQ;
  assign io_ovf      = ovfQ;
  assign io_snap_cnt = snapCntQ;
  assign io_snap_vld = snapVldQ;

`ifdef FB_TIMEOUT_EN
  fb_timeout_timer #(
    ._RAM_WIDTH(_RAM_WIDTH)
  ) uTimer (
    .io_clk        (io_clk),
    .io_rst_n      (io_rst_n),
    .io_catch      (io_fb_catch),
    .io_clr        (io_clr),
    .io_arm        (io_arm),
    .io_timeout_cnt(io_timeout_cnt),
    .io_busy       (io_busy),
    .io_hit        (io_hit),
    .io_timeout    (io_timeout)
  );
`else
  logic unusedTimerInputs;
  assign unusedTimerInputs = ^{io_arm, io_timeout_cnt};
  assign io_busy    = 1'b0;
  assign io_hit     = 1'b0;
  assign io_timeout = 1'b0;
`endif

endmodule
